// File: rtl/popcount_engine_if.sv
// Word/result handshake bundle for popcount_engine: valid/ready in, valid/ready out.
// The engine takes the slave side and the producer/consumer take the master side.
interface popcount_engine_if #(
    parameter int WIDTH = 8
);
    logic                         in_valid;
    logic                         in_ready;
    logic [WIDTH-1:0]             in_data;
    logic                         in_mode;
    logic                         out_valid;
    logic                         out_ready;
    logic [$clog2(WIDTH+1)-1:0]   out_count;

    modport master (
        output in_valid, in_data, in_mode, out_ready,
        input  in_ready, out_valid, out_count
    );

    modport slave (
        input  in_valid, in_data, in_mode, out_ready,
        output in_ready, out_valid, out_count
    );
endinterface

// File: rtl/popcount_engine.sv
// Bit-count engine: clears up to STRIDE lowest set bits per cycle, result after max(1,ceil(p/STRIDE)) cycles.
// One word in flight; the result is held in DONE until out_ready, and no word is accepted meanwhile.
module popcount_engine #(
    parameter int WIDTH  = 8,
    parameter int STRIDE = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    popcount_engine_if.slave   bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int KW = $clog2(STRIDE + 1);

    if (WIDTH < 1 || STRIDE < 1 || STRIDE > WIDTH) begin : g_bad_params
        $error("popcount_engine: need WIDTH >= 1 and STRIDE in 1..WIDTH");
    end

    typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

    state_t                   state_r, state_n;
    logic [WIDTH-1:0]         num_r, num_n;
    logic [CW-1:0]            ctr_r, ctr_n;
    logic [STRIDE:0][WIDTH-1:0] stage;
    logic [KW-1:0]            k;

    // Each stage drops the lowest set bit; k counts stages that had something to drop.
    always_comb begin
        stage[0] = num_r;
        k        = '0;
        for (int i = 0; i < STRIDE; i++) begin
            stage[i+1] = stage[i] & (stage[i] - 1'b1);
            if (stage[i] != '0) begin
                k = k + KW'(1);
            end
        end
    end

    always_comb begin
        state_n = state_r;
        num_n   = num_r;
        ctr_n   = ctr_r;
        case (state_r)
            IDLE: begin
                if (bus.in_valid && !clear) begin
                    num_n   = bus.in_mode ? ~bus.in_data : bus.in_data;
                    ctr_n   = '0;
                    state_n = COMPUTE;
                end
            end
            COMPUTE: begin
                num_n = stage[STRIDE];
                ctr_n = ctr_r + CW'(k);
                if (stage[STRIDE] == '0) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        // Abort overrides every transition, including a DONE handshake.
        if (clear) begin
            state_n = IDLE;
            num_n   = '0;
            ctr_n   = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            num_r   <= '0;
            ctr_r   <= '0;
        end else begin
            state_r <= state_n;
            num_r   <= num_n;
            ctr_r   <= ctr_n;
        end
    end

    assign bus.in_ready  = (state_r == IDLE) && !clear;
    assign bus.out_valid = (state_r == DONE);
    assign bus.out_count = ctr_r;
endmodule

// File: tb/tb_popcount_engine.sv
// Randomized bench for popcount_engine over several WIDTH/STRIDE builds against a popcount reference.
module tb_popcount_engine;
    localparam int NC = 8;

    function automatic int cfg_w(input int c);
        case (c)
            0, 1, 2, 3: return 8;
            4:          return 1;
            default:    return 13;
        endcase
    endfunction

    function automatic int cfg_s(input int c);
        case (c)
            0:       return 2;
            1:       return 1;
            2:       return 3;
            3:       return 8;
            4:       return 1;
            5:       return 1;
            6:       return 3;
            default: return 13;
        endcase
    endfunction

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        a_in_valid  [NC];
    logic        a_in_mode   [NC];
    logic        a_out_ready [NC];
    logic        a_clear     [NC];
    logic [12:0] a_in_data   [NC];
    logic        a_in_ready  [NC];
    logic        a_out_valid [NC];
    logic [3:0]  a_out_count [NC];

    int n_checks = 0;
    int n_err    = 0;

    for (genvar g = 0; g < NC; g++) begin : g_dut
        localparam int W = cfg_w(g);
        localparam int S = cfg_s(g);
        popcount_engine_if #(.WIDTH(W)) bus ();
        assign bus.in_valid   = a_in_valid[g];
        assign bus.in_data    = a_in_data[g][W-1:0];
        assign bus.in_mode    = a_in_mode[g];
        assign bus.out_ready  = a_out_ready[g];
        assign a_in_ready[g]  = bus.in_ready;
        assign a_out_valid[g] = bus.out_valid;
        assign a_out_count[g] = 4'(bus.out_count);
        popcount_engine #(.WIDTH(W), .STRIDE(S)) dut (
            .clk   (clk),
            .rst   (rst),
            .clear (a_clear[g]),
            .bus   (bus.slave)
        );
    end

    function automatic int ref_count(input int w, input logic [12:0] d, input logic mode);
        int ones = 0;
        for (int i = 0; i < w; i++) ones += int'(d[i]);
        return mode ? (w - ones) : ones;
    endfunction

    function automatic int ref_lat(input int p, input int s);
        return (p == 0) ? 1 : (p + s - 1) / s;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input int c, input logic [12:0] d, input logic mode);
        int w = 0;
        while (!a_in_ready[c] && w < 50) begin
            tick();
            w++;
        end
        chk("in_ready_before_accept", 32'(a_in_ready[c]), 1);
        a_in_valid[c] = 1'b1;
        a_in_data[c]  = d;
        a_in_mode[c]  = mode;
        tick();
        a_in_valid[c] = 1'b0;
        a_in_data[c]  = 13'($urandom);
        a_in_mode[c]  = 1'($urandom_range(0, 1));
        chk("in_ready_busy", 32'(a_in_ready[c]), 0);
    endtask

    task automatic run_word(input int c, input logic [12:0] d, input logic mode, input int stall);
        int p, n, lat;
        p = ref_count(cfg_w(c), d, mode);
        n = ref_lat(p, cfg_s(c));
        accept(c, d, mode);
        lat = 0;
        while (!a_out_valid[c] && lat < 300) begin
            tick();
            lat++;
        end
        chk("latency", 32'(lat), 32'(n));
        chk("count", 32'(a_out_count[c]), 32'(p));
        for (int i = 0; i < stall; i++) begin
            tick();
            chk("hold_valid", 32'(a_out_valid[c]), 1);
            chk("hold_count", 32'(a_out_count[c]), 32'(p));
            chk("hold_in_ready", 32'(a_in_ready[c]), 0);
        end
        a_out_ready[c] = 1'b1;
        tick();
        a_out_ready[c] = 1'b0;
        chk("post_done_valid", 32'(a_out_valid[c]), 0);
        chk("post_done_in_ready", 32'(a_in_ready[c]), 1);
    endtask

    initial begin
        logic        saw;
        logic [12:0] d;
        logic [12:0] mask;
        rst = 1'b1;
        for (int c = 0; c < NC; c++) begin
            a_in_valid[c]  = 1'b0;
            a_in_mode[c]   = 1'b0;
            a_out_ready[c] = 1'b0;
            a_clear[c]     = 1'b0;
            a_in_data[c]   = '0;
        end
        #3;
        for (int c = 0; c < NC; c++) begin
            chk("reset_in_ready", 32'(a_in_ready[c]), 1);
            chk("reset_out_valid", 32'(a_out_valid[c]), 0);
            chk("reset_out_count", 32'(a_out_count[c]), 0);
        end
        #9 rst = 1'b0;
        tick();

        // Directed cases on fixed builds
        run_word(0, 13'h0B6, 1'b0, 0);
        run_word(0, 13'h0FF, 1'b1, 0);
        run_word(0, 13'h000, 1'b1, 0);
        run_word(1, 13'h0FF, 1'b0, 0);
        run_word(3, 13'h0A5, 1'b0, 5);

        // Abort on the third compute cycle
        accept(1, 13'h0FF, 1'b0);
        tick();
        tick();
        a_clear[1] = 1'b1;
        #1;
        chk("clear_in_ready", 32'(a_in_ready[1]), 0);
        tick();
        a_clear[1] = 1'b0;
        #1;
        chk("abort_in_ready", 32'(a_in_ready[1]), 1);
        chk("abort_count", 32'(a_out_count[1]), 0);
        saw = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (a_out_valid[1]) saw = 1'b1;
            tick();
        end
        chk("abort_no_valid", 32'(saw), 0);
        run_word(1, 13'h003, 1'b0, 0);

        // Clear blocks an accept in IDLE
        a_clear[0]    = 1'b1;
        a_in_valid[0] = 1'b1;
        a_in_data[0]  = 13'h0FF;
        #1;
        chk("clear_idle_in_ready", 32'(a_in_ready[0]), 0);
        tick();
        a_clear[0]    = 1'b0;
        a_in_valid[0] = 1'b0;
        #1;
        chk("clear_idle_not_taken", 32'(a_in_ready[0]), 1);

        // Asynchronous reset mid-compute
        accept(1, 13'h0FF, 1'b0);
        tick();
        tick();
        #2 rst = 1'b1;
        #1;
        chk("rst_in_ready", 32'(a_in_ready[1]), 1);
        chk("rst_out_valid", 32'(a_out_valid[1]), 0);
        chk("rst_out_count", 32'(a_out_count[1]), 0);
        #1 rst = 1'b0;
        tick();
        tick();
        chk("rst_stays_idle", 32'(a_in_ready[1]), 1);

        // Random words on every build
        for (int c = 0; c < NC; c++) begin
            mask = 13'((1 << cfg_w(c)) - 1);
            for (int j = 0; j < 30; j++) begin
                d = 13'($urandom) & mask;
                if ($urandom_range(0, 7) == 0) d = mask;
                if ($urandom_range(0, 7) == 0) d = '0;
                run_word(c, d, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule

// File: doc/popcount_engine.md
# popcount_engine

Streaming bit-count engine: counts asserted (or deasserted) bits of a WIDTH-bit word by iteratively clearing up to STRIDE lowest set bits per cycle. It adds valid/ready handshakes on input and output, a count-zeros mode, and a synchronous abort. It sits between a producer stream and a result consumer and replaces the single-bit-per-cycle fsm/datapath pair.

## Interface
- WIDTH, 8, input word width; legal range ≥1.
- STRIDE, 1, maximum set bits cleared per compute cycle; legal range 1..WIDTH. Elaboration error if out of range.
- clk  in  1  clock, rising-edge.
- rst  in  1  reset, asynchronous, active-high.
- clear  in  1  synchronous abort; returns the engine to IDLE and drops any in-flight or pending result.
- in_valid  in  1  input word valid.
- in_ready  out  1  engine can accept a word.
- in_data  in  WIDTH  word to count.
- in_mode  in  1  0 = count ones, 1 = count zeros; sampled with in_data.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_count  out  $clog2(WIDTH+1)  bit count.

## Operation
- States: IDLE, COMPUTE, DONE. Reset puts the engine in IDLE with num_r=0 and ctr_r=0.
- IDLE:
  - in_ready = !clear.
  - On in_valid && in_ready: num_r <= in_mode ? ~in_data : in_data; ctr_r <= 0; go to COMPUTE.
- COMPUTE, each cycle:
  - k = min(STRIDE, popcount(num_r)).
  - num_r <= num_r with its k lowest set bits cleared. Use a cascade of STRIDE stages of x & (x-1); no full popcount tree on num_r.
  - ctr_r <= ctr_r + k.
  - If the post-clear value is 0, go to DONE; otherwise stay in COMPUTE.
  - A zero word still spends exactly one COMPUTE cycle.
- DONE:
  - out_valid = 1 and out_count = ctr_r, both held stable until the handshake.
  - On out_ready, go to IDLE.
  - in_ready = 0; there is no overlap of the next accept with result delivery.
- out_count = ctr_r in all states. It is only meaningful while out_valid = 1.
- Width rules:
  - ctr_r is $clog2(WIDTH+1) bits and cannot overflow, since the maximum value is WIDTH.
  - k fits in $clog2(STRIDE+1) bits and is zero-extended before the add.
- clear has priority over every transition:
  - In any state: next state IDLE, ctr_r <= 0, num_r <= 0.
  - In IDLE with in_valid=1: in_ready is 0, so the word is not accepted.
  - In DONE with out_ready=1: the result is considered dropped, and the consumer must ignore that beat.

## Timing
- Reset values: in_ready=1 (when clear=0), out_valid=0, out_count=0.
- Reset is asynchronous; every register clears immediately regardless of state, including mid-COMPUTE and in DONE.
- Latency: with p = popcount of the loaded word (after the mode inversion), N = max(1, ceil(p/STRIDE)). out_valid rises exactly N rising edges after the accepting edge.
- Throughput: one word per N+2 cycles when out_ready is held high (accept, N compute cycles, 1 DONE cycle).
- in_ready and out_valid are pure state decodes, with no combinational path from out_ready or in_valid. The exception is in_ready, which depends combinationally on clear.
- Backpressure: out_valid, out_count and state are held indefinitely while out_ready=0.

## Test plan
- WIDTH=8, STRIDE=2, in_mode=0, in_data=8'b1011_0110:
  - out_count=5, out_valid 3 edges after accept.
  - out_ready=1 gives in_ready high again 1 cycle after the DONE beat.
- WIDTH=8, STRIDE=2, in_mode=1:
  - in_data=8'hFF → out_count=0, N=1.
  - in_data=8'h00 → out_count=8, N=4.
- WIDTH=8, STRIDE=1, in_data=8'hFF, mode 0:
  - out_count=8, out_valid exactly 8 edges after accept.
- STRIDE=WIDTH=8, in_data=8'hA5:
  - out_count=4, N=1.
  - Hold out_ready=0 for 5 cycles: out_valid=1, out_count=4 stable, in_ready=0 throughout.
- Abort/reset:
  - 8'hFF, STRIDE=1: assert clear on the 3rd COMPUTE cycle → IDLE next edge, out_valid never asserts; a new word 8'h03 then yields 2.
  - Assert rst mid-COMPUTE → outputs immediately return to reset values.
  - clear together with in_valid in IDLE → word not accepted.
- Back-to-back random words across all WIDTH∈{1,8,13} and STRIDE∈{1,3,WIDTH}, with random out_ready stalls: every out_count matches the reference popcount (ones or zeros per mode), and every latency equals N.
